tdm_demux: RTL
==============

# tdm_demux

Receive-side counterpart of the 2:1 data-level multiplexer: takes the single muxed bit line plus its select, routes each accepted bit back to channel A (s=0) or channel B (s=1), and deserializes each channel into WORD-bit words with a valid/ready handshake. It also checks that the A/B interleave alternates and flags overflow when a word completes before the previous one was taken. It sits at the far end of the muxed link, feeding two independent word consumers.

## Interface
- WORD, 8, bits per reassembled channel word (≥2)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- d  in  1  muxed data bit
- s  in  1  select tagging d: 0 = channel A, 1 = channel B
- in_valid  in  1  d/s are valid this cycle; no backpressure, bit always accepted
- a_bit  out  1  last accepted channel-A bit
- b_bit  out  1  last accepted channel-B bit
- a_word  out  WORD  completed channel-A word, first-received bit in [0]
- a_valid  out  1  a_word holds an untaken word
- a_ready  in  1  consumer takes a_word when a_valid & a_ready
- b_word, b_valid, b_ready: as for A, channel B
- seq_err  out  1  one-cycle pulse: interleave violation
- ovf  out  1  sticky: a word was overwritten before being taken (either channel)

## Operation
- Accept: in_valid=1 at a rising edge. s selects channel; other channel untouched.
- Per channel: shift register sr, counter cnt (0..WORD-1). On accept: sr <= {d, sr[WORD-1:1]}, x_bit <= d, cnt++.
- Completion: accept with cnt==WORD-1 → x_word <= {d, sr[WORD-1:1]}, x_valid <= 1, cnt <= 0.
- Handshake: x_valid & x_ready at an edge with no completion → x_valid <= 0. x_word stable while x_valid=1 except on overwrite.
- Completion while x_valid=1 and x_ready=0 → overwrite x_word, x_valid stays 1, ovf <= 1.
- Completion in same cycle as take (x_valid & x_ready) → new word loaded, x_valid stays 1, no ovf.
- Phase FSM: states EXP_A (reset), EXP_B. On every accept, next state = (s ? EXP_A : EXP_B).
- seq_err = registered (in_valid & s ≠ expected channel); pulses one cycle after the offending accept. Offending bit still routed per s; no resync discard.
- ovf clears only on rst.
- in_valid=0: no state change except handshake take.

## Timing
- Reset values: a_bit=b_bit=0, a_word=b_word=0, a_valid=b_valid=0, seq_err=0, ovf=0; cnts=0; FSM=EXP_A.
- rst mid-word discards partial bits; rst wins over all simultaneous events.
- All outputs registered; no combinational input→output path.
- Latency: bit accepted at edge k → x_bit updated after edge k; last bit of word at edge k → x_valid=1 and x_word valid after edge k; seq_err high for the cycle after edge k.
- Take at edge k → x_valid=0 after edge k (unless completion at edge k).
- Sustained throughput: one bit per clock, no bubbles required.

## Test plan
- Reset: rst=1 two cycles with random inputs → all outputs 0, FSM=EXP_A; first accept with s=1 gives seq_err pulse.
- Interleave, WORD=8: 16 back-to-back accepts alternating s=0,1, A bits 0xA5 and B bits 0x3C LSB first, ready=1 → a_word=0xA5 and b_word=0x3C each valid exactly one cycle, seq_err never set; repeat with in_valid low every other cycle → identical words.
- Sequence error: accepts s=0,s=0,s=1 → one seq_err pulse after second accept; both s=0 bits land in channel A (a_cnt=2); third accept no error.
- Overflow: a_ready=0, send A words 0x11 then 0x22 → ovf=1 after second completion, a_word=0x22, a_valid=1; ovf holds until rst.
- Take/complete collision: a_valid=1 with 0x11, a_ready=1 on the edge completing 0x22 → a_valid stays 1, a_word=0x22, ovf=0.
- Reset mid-word: 4 A bits, rst one cycle, then 8 A bits 0x5A → a_word=0x5A, no stale bits.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive side of the 2:1 bit-level TDM link: routes each accepted bit to channel A or B,
// reassembles WORD-bit words per channel with valid/ready, and flags interleave/overflow faults.
module tdm_demux #(
  parameter int unsigned WORD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d,
  input  logic            s,
  input  logic            in_valid,
  output logic            a_bit,
  output logic            b_bit,
  output logic [WORD-1:0] a_word,
  output logic            a_valid,
  input  logic            a_ready,
  output logic [WORD-1:0] b_word,
  output logic            b_valid,
  input  logic            b_ready,
  output logic            seq_err,
  output logic            ovf
);

  localparam int unsigned CntW = (WORD > 2) ? $clog2(WORD) : 1;

  localparam logic EXP_A = 1'b0;
  localparam logic EXP_B = 1'b1;

  // Index 0 is channel A, index 1 is channel B.
  // sr holds only the WORD-1 most recent bits; the oldest bit is never needed again.
  logic [1:0][WORD-2:0] sr_q, sr_d;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0][WORD-1:0] word_q, word_d;
  logic [1:0]           bit_q, bit_d;
  logic [1:0]           valid_q, valid_d;
  logic                 phase_q, phase_d;
  logic                 seq_err_q, seq_err_d;
  logic                 ovf_q, ovf_d;

  logic [1:0] accept;
  logic [1:0] complete;
  logic [1:0] rdy;

  assign accept = {in_valid & s, in_valid & ~s};
  assign rdy    = {b_ready, a_ready};

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    bit_d     = bit_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    complete  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      complete[i] = accept[i] && (cnt_q[i] == CntW'(WORD - 1));
      if (accept[i]) begin
        sr_d[i]  = (WORD - 1)'({d, sr_q[i]} >> 1);
        bit_d[i] = d;
        cnt_d[i] = complete[i] ? '0 : cnt_q[i] + CntW'(1);
      end
      if (complete[i]) begin
        word_d[i]  = {d, sr_q[i]};
        valid_d[i] = 1'b1;
        // A completion that coincides with a take is a clean hand-over, not an overwrite.
        if (valid_q[i] && !rdy[i]) begin
          ovf_d = 1'b1;
        end
      end else if (valid_q[i] && rdy[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    phase_d   = phase_q;
    seq_err_d = 1'b0;
    if (in_valid) begin
      seq_err_d = (s != (phase_q == EXP_B));
      phase_d   = s ? EXP_A : EXP_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      bit_q     <= '0;
      valid_q   <= '0;
      phase_q   <= EXP_A;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      phase_q   <= phase_d;
      seq_err_q <= seq_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign a_bit   = bit_q[0];
  assign b_bit   = bit_q[1];
  assign a_word  = word_q[0];
  assign b_word  = word_q[1];
  assign a_valid = valid_q[0];
  assign b_valid = valid_q[1];
  assign seq_err = seq_err_q;
  assign ovf     = ovf_q;

endmodule
